ctrl_pipe: RTL

Registered, handshaked successor to the combinational instruction decoder; sits between the IF/ID register and the execute stage. Decodes one 32-bit MIPS instruction per cycle into a packed control word, and inserts bubbles on load-use hazards against a configurable number of in-flight loads. It also traps on illegal encodings. One cycle of latency, with valid/ready flow control on both sides.

---
 rtl/ctrl_pipe.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ctrl_pipe.sv
// Registered MIPS control decoder with valid/ready handshakes, load-use bubble
// insertion against HAZARD_DEPTH in-flight loads, and an optional trap on illegal words.
module ctrl_pipe #(
   parameter int unsigned HAZARD_DEPTH = 1,
   parameter bit          ILLEGAL_TRAP = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [4:0]  out_rd,
   output logic        out_reg_write,
   output logic        out_mem_read,
   output logic        out_mem_write,
   output logic        out_alu_src,
   output logic        out_jump,
   output logic        out_jal,
   output logic        out_jr,
   output logic [3:0]  out_alu_op,
   output logic [1:0]  out_ext_op,
   output logic [2:0]  out_br,
   output logic        out_illegal,
   output logic [15:0] stall_cnt
);

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_OR  = 4'd2;
   localparam logic [3:0] ALU_SRL = 4'd3;
   localparam logic [3:0] ALU_SLL = 4'd4;
   localparam logic [3:0] ALU_SLT = 4'd5;
   localparam logic [3:0] ALU_AND = 4'd6;
   localparam logic [3:0] ALU_XOR = 4'd7;
   localparam logic [3:0] ALU_SRA = 4'd8;

   typedef enum logic {RUN, TRAP} state_t;

   state_t state, state_next;

   logic [5:0] opcode, funct;
   logic [4:0] rs, rt;

   logic       d_legal, d_alu, d_lw, d_sw, d_alu_src, d_jump, d_jal, d_jr;
   logic       d_reg_write, reads_rs, reads_rt;
   logic [3:0] d_alu_op;
   logic [1:0] d_ext_op;
   logic [2:0] d_br;
   logic [4:0] d_rd;

   logic [HAZARD_DEPTH-1:0]      hist_valid;
   logic [HAZARD_DEPTH-1:0][4:0] hist_rd;

   logic hazard, accept, out_free;

   assign opcode = instr[31:26];
   assign funct  = instr[5:0];
   assign rs     = instr[25:21];
   assign rt     = instr[20:16];

   always_comb begin
      d_legal   = 1'b0;
      d_alu     = 1'b0;
      d_lw      = 1'b0;
      d_sw      = 1'b0;
      d_alu_src = 1'b0;
      d_jump    = 1'b0;
      d_jal     = 1'b0;
      d_jr      = 1'b0;
      d_alu_op  = ALU_ADD;
      d_ext_op  = 2'b00;
      d_br      = 3'd0;
      d_rd      = rt;
      reads_rs  = 1'b0;
      reads_rt  = 1'b0;
      case (opcode)
         6'h00: begin
            d_rd     = instr[15:11];
            d_legal  = 1'b1;
            d_alu    = 1'b1;
            reads_rs = 1'b1;
            reads_rt = 1'b1;
            case (funct)
               6'h20, 6'h21: d_alu_op = ALU_ADD;
               6'h22, 6'h23: d_alu_op = ALU_SUB;
               6'h24: d_alu_op = ALU_AND;
               6'h25: d_alu_op = ALU_OR;
               6'h26: d_alu_op = ALU_XOR;
               6'h00: begin d_alu_op = ALU_SLL; reads_rs = 1'b0; end
               6'h02: begin d_alu_op = ALU_SRL; reads_rs = 1'b0; end
               6'h03: begin d_alu_op = ALU_SRA; reads_rs = 1'b0; end
               6'h04: d_alu_op = ALU_SLL;
               6'h06: d_alu_op = ALU_SRL;
               6'h07: d_alu_op = ALU_SRA;
               6'h08: begin
                  d_alu    = 1'b0;
                  reads_rt = 1'b0;
                  d_jr     = 1'b1;
                  d_jump   = 1'b1;
               end
               default: d_legal = 1'b0;
            endcase
         end
         6'h01: if (rt == 5'd1) begin
            d_legal  = 1'b1;
            d_br     = 3'd4;
            d_ext_op = 2'b10;
            reads_rs = 1'b1;
         end
         6'h02: begin d_legal = 1'b1; d_jump = 1'b1; end
         6'h03: begin d_legal = 1'b1; d_jump = 1'b1; d_jal = 1'b1; d_rd = 5'd31; end
         6'h04, 6'h05: begin
            d_legal  = 1'b1;
            d_br     = (opcode == 6'h04) ? 3'd1 : 3'd2;
            d_ext_op = 2'b10;
            d_alu_op = ALU_SUB;
            reads_rs = 1'b1;
            reads_rt = 1'b1;
         end
         6'h07: begin
            d_legal  = 1'b1;
            d_br     = 3'd3;
            d_ext_op = 2'b10;
            reads_rs = 1'b1;
         end
         6'h08, 6'h09, 6'h0A: begin
            d_legal   = 1'b1;
            d_alu     = 1'b1;
            d_alu_src = 1'b1;
            d_ext_op  = 2'b10;
            d_alu_op  = (opcode == 6'h0A) ? ALU_SLT : ALU_ADD;
            reads_rs  = 1'b1;
         end
         6'h0D: begin
            d_legal   = 1'b1;
            d_alu     = 1'b1;
            d_alu_src = 1'b1;
            d_alu_op  = ALU_OR;
            reads_rs  = 1'b1;
         end
         6'h0F: begin
            d_legal   = 1'b1;
            d_alu     = 1'b1;
            d_alu_src = 1'b1;
            d_ext_op  = 2'b01;
            d_alu_op  = ALU_OR;
         end
         6'h23, 6'h2B: begin
            d_legal   = 1'b1;
            d_lw      = (opcode == 6'h23);
            d_sw      = (opcode == 6'h2B);
            d_alu_src = 1'b1;
            d_ext_op  = 2'b10;
            reads_rs  = 1'b1;
            reads_rt  = (opcode == 6'h2B);
         end
         default: ;
      endcase
      // Illegal words leave the decoder as an inert NOP that reads nothing.
      if (!d_legal) begin
         d_alu     = 1'b0;
         d_lw      = 1'b0;
         d_sw      = 1'b0;
         d_alu_src = 1'b0;
         d_jump    = 1'b0;
         d_jal     = 1'b0;
         d_jr      = 1'b0;
         d_alu_op  = ALU_ADD;
         d_ext_op  = 2'b00;
         d_br      = 3'd0;
         d_rd      = 5'd0;
         reads_rs  = 1'b0;
         reads_rt  = 1'b0;
      end
      d_reg_write = (d_alu | d_lw | d_jal) & (d_rd != 5'd0);
   end

   always_comb begin
      hazard = 1'b0;
      for (int unsigned i = 0; i < HAZARD_DEPTH; i++) begin
         if (hist_valid[i] && ((reads_rs && hist_rd[i] == rs) || (reads_rt && hist_rd[i] == rt)))
            hazard = 1'b1;
      end
      // Only a word that could otherwise be taken counts as a stall.
      hazard = hazard & in_valid & (state == RUN) & ~flush;
   end

   assign out_free = ~out_valid | out_ready;
   assign in_ready = ~reset & (state == RUN) & ~flush & ~hazard & out_free;
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_next = state;
      if (flush)
         state_next = RUN;
      else if (state == RUN && accept && !d_legal && ILLEGAL_TRAP)
         state_next = TRAP;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= RUN;
         out_valid     <= 1'b0;
         out_instr     <= '0;
         out_rd        <= '0;
         out_reg_write <= 1'b0;
         out_mem_read  <= 1'b0;
         out_mem_write <= 1'b0;
         out_alu_src   <= 1'b0;
         out_jump      <= 1'b0;
         out_jal       <= 1'b0;
         out_jr        <= 1'b0;
         out_alu_op    <= '0;
         out_ext_op    <= '0;
         out_br        <= '0;
         out_illegal   <= 1'b0;
         stall_cnt     <= '0;
         hist_valid    <= '0;
         hist_rd       <= '0;
      end else begin
         state <= state_next;
         if (hazard && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
         if (flush) begin
            out_valid  <= 1'b0;
            hist_valid <= '0;
         end else begin
            if (out_free) begin
               out_valid <= accept;
               if (accept) begin
                  out_instr     <= instr;
                  out_rd        <= d_rd;
                  out_reg_write <= d_reg_write;
                  out_mem_read  <= d_lw;
                  out_mem_write <= d_sw;
                  out_alu_src   <= d_alu_src;
                  out_jump      <= d_jump;
                  out_jal       <= d_jal;
                  out_jr        <= d_jr;
                  out_alu_op    <= d_alu_op;
                  out_ext_op    <= d_ext_op;
                  out_br        <= d_br;
                  out_illegal   <= ~d_legal;
               end
            end
            if (out_ready) begin
               for (int unsigned i = 1; i < HAZARD_DEPTH; i++) begin
                  hist_valid[i] <= hist_valid[i-1];
                  hist_rd[i]    <= hist_rd[i-1];
               end
               hist_valid[0] <= accept & d_lw & (d_rd != 5'd0);
               hist_rd[0]    <= d_rd;
            end
         end
      end
   end

endmodule
